// File: rtl/ps2_ascii_decoder_if.sv
// PS/2 line pair plus decoded-key outputs.
// master: keyboard / stimulus side, slave: the decoder.
interface ps2_ascii_decoder_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] keyin;
  logic       key_update;
  logic       frame_err;

  modport master (output ps2_clk, ps2_dat, input keyin, key_update, frame_err);
  modport slave  (input ps2_clk, ps2_dat, output keyin, key_update, frame_err);
endinterface

// File: rtl/ps2_ascii_decoder.sv
// PS/2 scan-code-set-2 receiver and letter decoder.
// Frames are sampled on falling edges of the synchronised ps2_clk. Good bytes
// feed a small NORMAL/BREAK/EXT decoder. Letter make codes become uppercase
// ASCII on keyin with a one-cycle key_update strobe.
// Optional mid-frame inactivity abort: define PS2_TIMEOUT_EN.
module ps2_ascii_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int REPEAT_FILTER  = 1,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                clk,
  input  logic                reset_n,
  ps2_ascii_decoder_if.slave  ps2
);

  generate
    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 8191) begin : g_bad_param
      $error("ps2_ascii_decoder: SYNC_STAGES must be >= 2, TIMEOUT_CYCLES 1..8191");
    end
  endgenerate

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_PARITY, R_STOP} rx_state_t;
  typedef enum logic [1:0] {D_NORMAL, D_BREAK, D_EXT} dec_state_t;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;

  // Set-2 make code to uppercase ASCII; 8'h00 means "not a letter".
  function automatic logic [7:0] key_map(input logic [7:0] code);
    case (code)
      8'h1C: return 8'h41;  8'h32: return 8'h42;  8'h21: return 8'h43;
      8'h23: return 8'h44;  8'h24: return 8'h45;  8'h2B: return 8'h46;
      8'h34: return 8'h47;  8'h33: return 8'h48;  8'h43: return 8'h49;
      8'h3B: return 8'h4A;  8'h42: return 8'h4B;  8'h4B: return 8'h4C;
      8'h3A: return 8'h4D;  8'h31: return 8'h4E;  8'h44: return 8'h4F;
      8'h4D: return 8'h50;  8'h15: return 8'h51;  8'h2D: return 8'h52;
      8'h1B: return 8'h53;  8'h2C: return 8'h54;  8'h3C: return 8'h55;
      8'h2A: return 8'h56;  8'h1D: return 8'h57;  8'h22: return 8'h58;
      8'h35: return 8'h59;  8'h1A: return 8'h5A;
      default: return 8'h00;
    endcase
  endfunction

  // Reset: asserts immediately, releases two clk edges after reset_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Reset release synchroniser.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Line synchronisers reset to the idle-high level so release cannot fake an edge.
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;

  // Metastability chains for the asynchronous PS/2 lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2.ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2.ps2_dat};
    end
  end

  logic ps2c_s, bit_in, sample;
  assign ps2c_s = clk_sync_q[SYNC_STAGES-1];
  assign bit_in = dat_sync_q[SYNC_STAGES-1];

  rx_state_t  rx_q, rx_d;
  dec_state_t dec_q, dec_d;
  logic       ps2c_prev_q, ps2c_prev_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] last_make_q, last_make_d;
  logic [7:0] keyin_q, keyin_d;
  logic       key_update_q, key_update_d;
  logic       frame_err_q, frame_err_d;
  logic       byte_ok;
  logic [7:0] ascii;
`ifdef PS2_TIMEOUT_EN
  localparam logic [12:0] TMO_LAST = 13'(TIMEOUT_CYCLES - 1);
  logic [12:0] tmo_q, tmo_d;
`endif

  assign sample = ps2c_prev_q & ~ps2c_s;
  assign ascii  = key_map(shift_q);

  // Next-state: frame receiver, optional timeout, then byte decoder.
  always_comb begin
    rx_d         = rx_q;
    dec_d        = dec_q;
    ps2c_prev_d  = ps2c_s;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    last_make_d  = last_make_q;
    keyin_d      = keyin_q;
    key_update_d = 1'b0;
    frame_err_d  = 1'b0;
    byte_ok      = 1'b0;

    if (sample) begin
      case (rx_q)
        R_IDLE: begin
          // A high level here is just idle line, not a framing error.
          if (!bit_in) begin
            rx_d      = R_DATA;
            bit_cnt_d = 4'd0;
          end
        end
        R_DATA: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) rx_d = R_PARITY;
        end
        R_PARITY: begin
          // Odd parity over the 9 bits; a bad frame is dropped right here.
          if (^{shift_q, bit_in}) rx_d = R_STOP;
          else begin
            rx_d        = R_IDLE;
            frame_err_d = 1'b1;
          end
        end
        default: begin
          rx_d = R_IDLE;
          if (bit_in) byte_ok     = 1'b1;
          else        frame_err_d = 1'b1;
        end
      endcase
    end

`ifdef PS2_TIMEOUT_EN
    tmo_d = tmo_q;
    if (sample || rx_q == R_IDLE) tmo_d = 13'd0;
    else if (tmo_q == TMO_LAST) begin
      tmo_d       = 13'd0;
      rx_d        = R_IDLE;
      frame_err_d = 1'b1;
    end else tmo_d = tmo_q + 13'd1;
`endif

    if (byte_ok) begin
      case (dec_q)
        D_NORMAL: begin
          if (shift_q == CODE_BREAK)    dec_d = D_BREAK;
          else if (shift_q == CODE_EXT) dec_d = D_EXT;
          else if (ascii != 8'h00) begin
            if (!(REPEAT_FILTER != 0 && shift_q == last_make_q)) begin
              keyin_d      = ascii;
              key_update_d = 1'b1;
              last_make_d  = shift_q;
            end
          end
        end
        D_BREAK: begin
          // Releasing the held key re-arms it for the next press.
          if (shift_q == last_make_q) last_make_d = 8'h00;
          dec_d = D_NORMAL;
        end
        default: begin
          // No extended key is mapped; only an extended break matters.
          dec_d = (shift_q == CODE_BREAK) ? D_BREAK : D_NORMAL;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q         <= R_IDLE;
      dec_q        <= D_NORMAL;
      ps2c_prev_q  <= 1'b1;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      last_make_q  <= 8'h00;
      keyin_q      <= 8'h00;
      key_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      tmo_q        <= 13'd0;
`endif
    end else begin
      rx_q         <= rx_d;
      dec_q        <= dec_d;
      ps2c_prev_q  <= ps2c_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      last_make_q  <= last_make_d;
      keyin_q      <= keyin_d;
      key_update_q <= key_update_d;
      frame_err_q  <= frame_err_d;
`ifdef PS2_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign ps2.keyin      = keyin_q;
  assign ps2.key_update = key_update_q;
  assign ps2.frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Bench for ps2_ascii_decoder: directed scenarios plus a randomized frame
// stream checked against a table-driven keyboard model.
module tb_ps2_ascii_decoder;
  localparam int HALF = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  ps2_ascii_decoder_if bus ();

  ps2_ascii_decoder #(.SYNC_STAGES(2), .REPEAT_FILTER(1), .TIMEOUT_CYCLES(5000)) dut (
    .clk(clk), .reset_n(reset_n), .ps2(bus)
  );

  always #10 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Output monitor: counts strobes and flags protocol glitches.
  int n_strobe = 0, n_ferr = 0, n_glitch = 0;
  logic [7:0] prev_key = 8'h00;
  logic prev_upd = 1'b0, prev_ferr = 1'b0, prev_rst = 1'b0;
  always @(negedge clk) begin
    if (bus.key_update === 1'b1) n_strobe <= n_strobe + 1;
    if (bus.frame_err === 1'b1)  n_ferr   <= n_ferr + 1;
    if (reset_n && prev_rst) begin
      if (bus.keyin !== prev_key && bus.key_update !== 1'b1) n_glitch <= n_glitch + 1;
      if (bus.key_update === 1'b1 && prev_upd)               n_glitch <= n_glitch + 1;
      if (bus.frame_err === 1'b1 && prev_ferr)               n_glitch <= n_glitch + 1;
    end
    prev_key  <= bus.keyin;
    prev_upd  <= bus.key_update;
    prev_ferr <= bus.frame_err;
    prev_rst  <= reset_n;
  end

  // Keyboard model: letter table, pending break/extended flags, held key.
  logic [7:0] codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                             8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                             8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  bit         m_brk = 0, m_ext = 0;
  logic [7:0] m_last = 8'h00, m_key = 8'h00;

  function automatic int letter_idx(input logic [7:0] b);
    for (int i = 0; i < 26; i++) if (codes[i] == b) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_last = 8'h00; m_key = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b, output int strobes);
    int idx;
    strobes = 0;
    idx = letter_idx(b);
    if (m_brk) begin
      if (b == m_last) m_last = 8'h00;
      m_brk = 0;
    end else if (m_ext) begin
      m_ext = 0;
      if (b == 8'hF0) m_brk = 1;
    end else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (idx >= 0 && b != m_last) begin
      m_key   = 8'h41 + 8'(idx);
      m_last  = b;
      strobes = 1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b);
    @(posedge clk); #1 bus.ps2_dat = b;
    repeat (HALF) @(posedge clk);
    #1 bus.ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 bus.ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) ps2_bit(f[i]);
    @(posedge clk); #1 bus.ps2_dat = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  // Send one frame and compare strobe count, error count and keyin with the model.
  task automatic check_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input string nm);
    int s0, f0, exp_s, exp_f;
    s0 = n_strobe; f0 = n_ferr;
    send_bits(mk_frame(d, bad_par, bad_stop), 0, 10);
    @(negedge clk);
    if (bad_par || bad_stop) begin exp_s = 0; exp_f = 1; end
    else begin model_byte(d, exp_s); exp_f = 0; end
    vectors += 3;
    if (n_strobe - s0 !== exp_s) begin errors++;
      $display("FAIL %s strobes got %0d want %0d (byte %h)", nm, n_strobe - s0, exp_s, d); end
    if (n_ferr - f0 !== exp_f) begin errors++;
      $display("FAIL %s frame_err got %0d want %0d (byte %h)", nm, n_ferr - f0, exp_f, d); end
    if (bus.keyin !== m_key) begin errors++;
      $display("FAIL %s keyin got %h want %h (byte %h)", nm, bus.keyin, m_key, d); end
  endtask

  task automatic test_reset();
    bus.ps2_clk = 1'b1; bus.ps2_dat = 1'b1; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 3;
    if (bus.keyin !== 8'h00) begin errors++; $display("FAIL reset_keyin got %h want 00", bus.keyin); end
    if (bus.key_update !== 1'b0) begin errors++; $display("FAIL reset_update got %b want 0", bus.key_update); end
    if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", bus.frame_err); end
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    model_reset();
  endtask

  task automatic test_basic();
    logic [10:0] f;
    int lat, s0, exp_s;
    bit seen;
    f = mk_frame(8'h32, 0, 0);
    s0 = n_strobe;
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    @(posedge clk); #1 bus.ps2_dat = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 bus.ps2_clk = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 12) begin
      @(negedge clk); lat++;
      if (bus.key_update === 1'b1) seen = 1;
    end
    model_byte(8'h32, exp_s);
    vectors += 2;
    if (!seen || lat > 6) begin errors++;
      $display("FAIL basic_latency got %0d cycles (seen=%0d) want <=6", lat, seen); end
    if (bus.keyin !== 8'h42) begin errors++; $display("FAIL basic_keyin got %h want 42", bus.keyin); end
    repeat (HALF) @(posedge clk);
    #1 bus.ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (n_strobe - s0 !== exp_s) begin errors++;
      $display("FAIL basic_strobes got %0d want %0d", n_strobe - s0, exp_s); end
  endtask

  task automatic test_repeat_filter();
    int s0;
    s0 = n_strobe;
    check_frame(8'h2D, 0, 0, "rep_make1");
    check_frame(8'h2D, 0, 0, "rep_typematic");
    check_frame(8'hF0, 0, 0, "rep_break");
    check_frame(8'h2D, 0, 0, "rep_release");
    check_frame(8'h2D, 0, 0, "rep_make2");
    vectors += 2;
    if (n_strobe - s0 !== 2) begin errors++; $display("FAIL rep_total got %0d want 2", n_strobe - s0); end
    if (bus.keyin !== 8'h52) begin errors++; $display("FAIL rep_keyin got %h want 52", bus.keyin); end
  endtask

  task automatic test_parity_err();
    logic [7:0] k0;
    k0 = bus.keyin;
    check_frame(8'h24, 1, 0, "parity_err");
    vectors++;
    if (bus.keyin !== k0) begin errors++; $display("FAIL parity_keyin got %h want %h", bus.keyin, k0); end
  endtask

  task automatic test_extended();
    check_frame(8'hE0, 0, 0, "ext_prefix");
    check_frame(8'h75, 0, 0, "ext_code");
    check_frame(8'h23, 0, 0, "ext_then_d");
    vectors++;
    if (bus.keyin !== 8'h44) begin errors++; $display("FAIL ext_keyin got %h want 44", bus.keyin); end
  endtask

  task automatic test_reset_midframe();
    logic [10:0] f;
    int s0;
    f = mk_frame(8'h2B, 0, 0);
    for (int i = 0; i < 5; i++) ps2_bit(f[i]);
    @(posedge clk); #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.ps2_dat = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.keyin !== 8'h00) begin errors++; $display("FAIL midrst_keyin got %h want 00", bus.keyin); end
    s0 = n_strobe;
    check_frame(8'h2B, 0, 0, "midrst_frame");
    vectors += 2;
    if (n_strobe - s0 !== 1) begin errors++; $display("FAIL midrst_strobes got %0d want 1", n_strobe - s0); end
    if (bus.keyin !== 8'h46) begin errors++; $display("FAIL midrst_keyin2 got %h want 46", bus.keyin); end
  endtask

`ifdef PS2_TIMEOUT_EN
  task automatic test_timeout();
    int f0, cyc;
    bit seen;
    f0 = n_ferr;
    send_bits(mk_frame(8'h1C, 0, 0), 0, 2);
    cyc = 0; seen = 0;
    while (!seen && cyc < 6000) begin
      @(negedge clk); cyc++;
      if (bus.frame_err === 1'b1) seen = 1;
    end
    vectors += 2;
    if (!seen || cyc < 4960 || cyc > 5010) begin errors++;
      $display("FAIL timeout_abort seen=%0d after %0d cycles want ~5000", seen, cyc); end
    repeat (4) @(negedge clk);
    if (n_ferr - f0 !== 1) begin errors++; $display("FAIL timeout_count got %0d want 1", n_ferr - f0); end
    check_frame(8'h1C, 0, 0, "timeout_next");
    vectors++;
    if (bus.keyin !== 8'h41) begin errors++; $display("FAIL timeout_keyin got %h want 41", bus.keyin); end
  endtask
`else
  task automatic test_truncated();
    logic [10:0] f;
    int f0, s0, exp_s;
    f = mk_frame(8'h1C, 0, 0);
    f0 = n_ferr; s0 = n_strobe;
    send_bits(f, 0, 2);
    repeat (300) @(posedge clk);
    send_bits(f, 3, 10);
    @(negedge clk);
    model_byte(8'h1C, exp_s);
    vectors += 3;
    if (n_ferr - f0 !== 0) begin errors++; $display("FAIL trunc_ferr got %0d want 0", n_ferr - f0); end
    if (n_strobe - s0 !== exp_s) begin errors++; $display("FAIL trunc_strobes got %0d want %0d", n_strobe - s0, exp_s); end
    if (bus.keyin !== 8'h41) begin errors++; $display("FAIL trunc_keyin got %h want 41", bus.keyin); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] b;
    int r;
    for (int n = 0; n < 45; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: b = codes[$urandom_range(0, 3)];
        5:       b = 8'hF0;
        6:       b = 8'hE0;
        7:       b = 8'($urandom);
        default: b = codes[$urandom_range(0, 25)];
      endcase
      check_frame(b, r == 8, r == 9, "random");
    end
  endtask

  task automatic test_invariants();
    vectors++;
    if (n_glitch !== 0) begin errors++;
      $display("FAIL invariants got %0d glitches want 0", n_glitch); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat_filter();
    test_parity_err();
    test_extended();
`ifdef PS2_TIMEOUT_EN
    test_timeout();
`else
    test_truncated();
`endif
    test_reset_midframe();
    test_random();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
